// File: rtl/intr_stack_ctrl.sv
// Prioritised, nestable interrupt controller with per-source masks,
// edge/level capture, a return-PC/level stack and a periodic timer source.
// Source 0 is the highest priority; the timer shares source 0 as an edge event.
module intr_stack_ctrl #(
  parameter int                N_SRC      = 4,
  parameter int                PC_W       = 10,
  parameter int                DEPTH      = 8,
  parameter int                TMR_W      = 7,
  parameter logic [N_SRC-1:0]  EDGE_MASK  = 'b0001,
  parameter logic [PC_W-1:0]   VEC_BASE   = 10'h3C0,
  parameter logic [PC_W-1:0]   VEC_STRIDE = 10'd4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_SRC-1:0]             irq,
  input  logic                         mask_we,
  input  logic [N_SRC-1:0]             mask_in,
  input  logic                         gie_we,
  input  logic                         gie_in,
  input  logic                         timer_en,
  input  logic [TMR_W-1:0]             timer_limit,
  input  logic [PC_W-1:0]              ret_pc_in,
  input  logic                         iret,
  output logic                         int_take,
  output logic [PC_W-1:0]              vector,
  output logic [PC_W-1:0]              ret_pc,
  output logic [N_SRC-1:0]             pending,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         err_uflow
);

  // Level encoding: 0..N_SRC-1 are source levels, N_SRC means "not in a handler".
  localparam int LVL_W = $clog2(N_SRC + 1);
  localparam int DEP_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] irq_hist_q, irq_hist_d;
  logic             gie_q, gie_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [DEP_W-1:0] depth_q, depth_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Return stack: PC to resume and the level that was interrupted.
  logic [PC_W-1:0]  stk_pc_q  [DEPTH];
  logic [LVL_W-1:0] stk_lvl_q [DEPTH];

  logic [N_SRC-1:0] elig;
  logic [LVL_W-1:0] win;
  logic             any_elig;
  logic             tick;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic [PC_W-1:0]  vec_off;

  assign elig    = pend_q & mask_q;
  assign wr_idx  = IDX_W'(depth_q);
  assign top_idx = IDX_W'(depth_q - DEP_W'(1));

  // Lowest-index eligible source wins; N_SRC when nothing is eligible.
  always_comb begin
    win      = LVL_W'(N_SRC);
    any_elig = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win      = LVL_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  // Free-running period counter; a limit of 0 never matches so it only wraps.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (!timer_en) begin
      cnt_d = '0;
    end else if ((timer_limit != '0) && (cnt_q == timer_limit)) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // iret has priority: a take is never granted in the same cycle as a return.
  assign int_take = gie_q & any_elig & (win < lvl_q) & (depth_q < DEP_W'(DEPTH)) & ~iret;
  assign vec_off  = PC_W'(win) * VEC_STRIDE;
  assign vector   = int_take ? (VEC_BASE + vec_off) : VEC_BASE;
  assign ret_pc   = (depth_q != '0) ? stk_pc_q[top_idx] : '0;

  assign pending   = pend_q;
  assign depth     = depth_q;
  assign err_uflow = err_q;
  assign irq_hist_d = irq;

  // Per-source capture. Edge sources hold until taken (a fresh edge re-arms in
  // the same cycle); level sources simply mirror the request line.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_pend
      localparam bit TMR_SRC = (gi == 0);
      assign pend_d[gi] = EDGE_MASK[gi]
          ? ((pend_q[gi] & ~(int_take & (win == LVL_W'(gi))))
             | (irq[gi] & ~irq_hist_q[gi])
             | (TMR_SRC & tick))
          : (irq[gi] | (TMR_SRC & tick));
    end
  endgenerate

  // Nesting control: push on take, pop on iret, flag a return with nothing to pop.
  always_comb begin
    lvl_d   = lvl_q;
    depth_d = depth_q;
    err_d   = err_q;
    mask_d  = mask_we ? mask_in : mask_q;
    gie_d   = gie_we ? gie_in : gie_q;
    if (int_take) begin
      lvl_d   = win;
      depth_d = depth_q + DEP_W'(1);
    end else if (iret) begin
      if (depth_q != '0) begin
        lvl_d   = stk_lvl_q[top_idx];
        depth_d = depth_q - DEP_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q     <= '0;
      mask_q     <= '0;
      irq_hist_q <= '0;
      gie_q      <= 1'b0;
      lvl_q      <= LVL_W'(N_SRC);
      depth_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      irq_hist_q <= irq_hist_d;
      gie_q      <= gie_d;
      lvl_q      <= lvl_d;
      depth_q    <= depth_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Stack storage; contents are only meaningful below depth_q, so no reset.
  always_ff @(posedge clk) begin
    if (reset && int_take) begin
      stk_pc_q[wr_idx]  <= ret_pc_in;
      stk_lvl_q[wr_idx] <= lvl_q;
    end
  end

endmodule

// File: tb/tb_intr_stack_ctrl.sv
// Bench for intr_stack_ctrl: a default build (a) and a DEPTH=2 build (b)
// share stimulus; directed vector table, hand sequences and random traffic
// compared against a rule-level reference model.
module tb_intr_stack_ctrl;

  localparam logic [3:0] EDGE = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       gie_we, gie_in;
  logic       timer_en;
  logic [6:0] timer_limit;
  logic [9:0] ret_pc_in;
  logic       iret;

  logic       take_a, take_b, err_a, err_b;
  logic [9:0] vec_a, vec_b, ret_a, ret_b;
  logic [3:0] pend_a, pend_b;
  logic [3:0] depth_a;
  logic [1:0] depth_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intr_stack_ctrl dut_a (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .gie_we(gie_we), .gie_in(gie_in), .timer_en(timer_en), .timer_limit(timer_limit),
    .ret_pc_in(ret_pc_in), .iret(iret), .int_take(take_a), .vector(vec_a),
    .ret_pc(ret_a), .pending(pend_a), .depth(depth_a), .err_uflow(err_a)
  );

  intr_stack_ctrl #(.DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .gie_we(gie_we), .gie_in(gie_in), .timer_en(timer_en), .timer_limit(timer_limit),
    .ret_pc_in(ret_pc_in), .iret(iret), .int_take(take_b), .vector(vec_b),
    .ret_pc(ret_b), .pending(pend_b), .depth(depth_b), .err_uflow(err_b)
  );

  logic       o_take [2];
  logic [9:0] o_vec  [2];
  logic [9:0] o_ret  [2];
  logic [3:0] o_pend [2];
  logic [3:0] o_dep  [2];
  logic       o_err  [2];

  always_comb begin
    o_take[0] = take_a;  o_take[1] = take_b;
    o_vec[0]  = vec_a;   o_vec[1]  = vec_b;
    o_ret[0]  = ret_a;   o_ret[1]  = ret_b;
    o_pend[0] = pend_a;  o_pend[1] = pend_b;
    o_dep[0]  = depth_a; o_dep[1]  = {2'b00, depth_b};
    o_err[0]  = err_a;   o_err[1]  = err_b;
  end

  // ---------------- reference model (one state set per build) ----------------
  int         DMAX [2] = '{8, 2};
  logic [3:0] m_pend [2];
  logic [3:0] m_mask [2];
  logic [3:0] m_irqd [2];
  bit         m_gie  [2];
  bit         m_err  [2];
  int         m_lvl  [2];
  int         m_dep  [2];
  int         m_cnt  [2];
  logic [9:0] m_pc   [2][8];
  int         m_sl   [2][8];
  bit         mchk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_win(int k);
    for (int i = 0; i < 4; i++)
      if (m_pend[k][i] && m_mask[k][i]) return i;
    return 4;
  endfunction

  function automatic bit m_take(int k);
    int w = m_win(k);
    return m_gie[k] && (w < 4) && (w < m_lvl[k]) && (m_dep[k] < DMAX[k]) && !iret;
  endfunction

  task automatic m_reset(int k);
    m_pend[k] = '0; m_mask[k] = '0; m_irqd[k] = '0;
    m_gie[k] = 1'b0; m_err[k] = 1'b0;
    m_lvl[k] = 4; m_dep[k] = 0; m_cnt[k] = 0;
  endtask

  task automatic m_adv(int k);
    bit tk, tick;
    int w;
    logic [3:0] np;
    if (reset == 1'b0) begin
      m_reset(k);
      return;
    end
    tk   = m_take(k);
    w    = m_win(k);
    tick = timer_en && (timer_limit != 0) && (m_cnt[k] == int'(timer_limit));
    for (int i = 0; i < 4; i++) begin
      if (EDGE[i])
        np[i] = (m_pend[k][i] && !(tk && w == i)) || (irq[i] && !m_irqd[k][i]) || (i == 0 && tick);
      else
        np[i] = irq[i] || (i == 0 && tick);
    end
    m_pend[k] = np;
    m_cnt[k]  = !timer_en ? 0 : (tick ? 0 : (m_cnt[k] + 1) % 128);
    if (tk) begin
      m_pc[k][m_dep[k]] = ret_pc_in;
      m_sl[k][m_dep[k]] = m_lvl[k];
      m_lvl[k] = w;
      m_dep[k]++;
    end else if (iret) begin
      if (m_dep[k] > 0) begin
        m_dep[k]--;
        m_lvl[k] = m_sl[k][m_dep[k]];
      end else begin
        m_err[k] = 1'b1;
      end
    end
    if (mask_we) m_mask[k] = mask_in;
    if (gie_we)  m_gie[k]  = gie_in;
    m_irqd[k] = irq;
  endtask

  task automatic m_cmp(int k);
    string      s;
    int         w;
    bit         tk;
    logic [9:0] ev, er;
    s  = (k == 0) ? "a" : "b";
    w  = m_win(k);
    tk = m_take(k);
    ev = tk ? (10'h3C0 + 10'(w * 4)) : 10'h3C0;
    er = (m_dep[k] > 0) ? m_pc[k][m_dep[k] - 1] : 10'h000;
    chk({"m_take_", s}, 32'(o_take[k]), 32'(tk));
    chk({"m_vector_", s}, 32'(o_vec[k]), 32'(ev));
    chk({"m_ret_pc_", s}, 32'(o_ret[k]), 32'(er));
    chk({"m_pending_", s}, 32'(o_pend[k]), 32'(m_pend[k]));
    chk({"m_depth_", s}, 32'(o_dep[k]), 32'(m_dep[k]));
    chk({"m_err_", s}, 32'(o_err[k]), 32'(m_err[k]));
  endtask

  // Mid-cycle sampling, then model advance alongside the DUT edge.
  task automatic half();
    @(negedge clk);
    if (mchk) begin
      m_cmp(0);
      m_cmp(1);
    end
  endtask

  task automatic fin();
    m_adv(0);
    m_adv(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    irq = '0; mask_we = 1'b0; mask_in = '0; gie_we = 1'b0; gie_in = 1'b0;
    iret = 1'b0; ret_pc_in = '0;
  endtask

  task automatic reset_enable();
    idle(); reset = 1'b0; half(); fin();
    reset = 1'b1; mask_we = 1'b1; mask_in = 4'hF; gie_we = 1'b1; gie_in = 1'b1;
    half(); fin();
    idle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; logic [3:0] irq; bit mwe; logic [3:0] min; bit gwe; bit gin; bit ir;
    logic [9:0] rpc; bit chk; bit tk; logic [9:0] vec; logic [3:0] pend;
    int dep; logic [9:0] ret; bit err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, logic [3:0] ri, bit mwe, logic [3:0] min, bit gwe, bit gin,
                             bit ir, logic [9:0] rpc, bit c, bit tk, logic [9:0] vec,
                             logic [3:0] pend, int dep, logic [9:0] ret, bit err);
    vec_t r;
    r.rst = rst; r.irq = ri; r.mwe = mwe; r.min = min; r.gwe = gwe; r.gin = gin; r.ir = ir;
    r.rpc = rpc; r.chk = c; r.tk = tk; r.vec = vec; r.pend = pend; r.dep = dep; r.ret = ret;
    r.err = err;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nt, last_t;
    bit do_iret;

    idle();
    reset = 1'b0; timer_en = 1'b0; timer_limit = '0;

    //         rst irq mwe min gwe gin ir  rpc     chk tk  vec     pend dep ret     err
    tbl.push_back(v(0, 4'hF, 0, 4'h0, 0, 0, 0, 10'h000, 0, 0, 10'h3C0, 4'h0, 0, 10'h000, 0));
    tbl.push_back(v(0, 4'hF, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 0));
    tbl.push_back(v(0, 4'hF, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 0));
    tbl.push_back(v(1, 4'h0, 1, 4'hF, 1, 1, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 0));
    tbl.push_back(v(1, 4'h4, 0, 4'h0, 0, 0, 0, 10'h050, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 0));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h050, 1, 1, 10'h3C8, 4'h4, 0, 10'h000, 0));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h060, 1, 0, 10'h3C0, 4'h0, 1, 10'h050, 0));
    tbl.push_back(v(1, 4'h2, 0, 4'h0, 0, 0, 0, 10'h060, 1, 0, 10'h3C0, 4'h0, 1, 10'h050, 0));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h070, 1, 1, 10'h3C4, 4'h2, 1, 10'h050, 0));
    tbl.push_back(v(1, 4'h8, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 2, 10'h070, 0));
    tbl.push_back(v(1, 4'h8, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h8, 2, 10'h070, 0));
    tbl.push_back(v(1, 4'h8, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h8, 2, 10'h070, 0));
    tbl.push_back(v(1, 4'h8, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h8, 1, 10'h050, 0));
    tbl.push_back(v(1, 4'h8, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h8, 1, 10'h050, 0));
    tbl.push_back(v(1, 4'h8, 0, 4'h0, 0, 0, 0, 10'h080, 1, 1, 10'h3CC, 4'h8, 0, 10'h000, 0));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h8, 1, 10'h080, 0));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 0));
    tbl.push_back(v(1, 4'h4, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h4, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h4, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h090, 1, 1, 10'h3C8, 4'h4, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h0, 1, 10'h090, 1));
    tbl.push_back(v(1, 4'h4, 1, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h4, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h4, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h4, 1, 4'hF, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h4, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h0A0, 1, 1, 10'h3C8, 4'h4, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h0, 1, 10'h0A0, 1));
    tbl.push_back(v(1, 4'h1, 0, 4'h0, 1, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h1, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h1, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 1, 1, 0, 10'h000, 1, 0, 10'h3C0, 4'h1, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h0B0, 1, 1, 10'h3C0, 4'h1, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h1, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 1, 10'h0B0, 1));
    tbl.push_back(v(1, 4'h1, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h1, 1, 10'h0B0, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h1, 1, 10'h0B0, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h0C0, 1, 1, 10'h3C0, 4'h1, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 1, 10'h000, 1, 0, 10'h3C0, 4'h0, 1, 10'h0C0, 1));
    tbl.push_back(v(1, 4'h1, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h0D0, 1, 1, 10'h3C0, 4'h1, 0, 10'h000, 1));
    tbl.push_back(v(0, 4'h0, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 1, 10'h0D0, 1));
    tbl.push_back(v(1, 4'h0, 0, 4'h0, 0, 0, 0, 10'h000, 1, 0, 10'h3C0, 4'h0, 0, 10'h000, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; irq = tbl[i].irq; mask_we = tbl[i].mwe; mask_in = tbl[i].min;
      gie_we = tbl[i].gwe; gie_in = tbl[i].gin; iret = tbl[i].ir; ret_pc_in = tbl[i].rpc;
      half();
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_take", i), 32'(take_a), 32'(tbl[i].tk));
        chk($sformatf("row%0d_vector", i), 32'(vec_a), 32'(tbl[i].vec));
        chk($sformatf("row%0d_pending", i), 32'(pend_a), 32'(tbl[i].pend));
        chk($sformatf("row%0d_depth", i), 32'(depth_a), 32'(tbl[i].dep));
        chk($sformatf("row%0d_ret_pc", i), 32'(ret_a), 32'(tbl[i].ret));
        chk($sformatf("row%0d_err", i), 32'(err_a), 32'(tbl[i].err));
      end
      fin();
      if (i == 0) mchk = 1'b1;
    end

    // ---- timer: limit 0 never ticks; limit 5 gives a take every 6 cycles ----
    reset_enable();
    timer_en = 1'b1; timer_limit = 7'd0; nt = 0;
    repeat (20) begin
      half();
      if (take_a) nt++;
      fin();
    end
    chk("tmr_limit0_takes", 32'(nt), 32'd0);
    timer_en = 1'b0; half(); fin();
    timer_en = 1'b1; timer_limit = 7'd5; nt = 0; last_t = -1; do_iret = 1'b0;
    for (int c = 0; c < 60; c++) begin
      iret = do_iret;
      half();
      do_iret = 1'b0;
      if (take_a) begin
        chk("tmr_vector", 32'(vec_a), 32'h3C0);
        if (last_t >= 0) chk("tmr_period", 32'(c - last_t), 32'd6);
        last_t = c; nt++; do_iret = 1'b1;
      end
      fin();
    end
    chk("tmr_take_count", 32'(nt), 32'd9);
    timer_en = 1'b0; idle();

    // ---- DEPTH=2 build: full stack holds a higher request until an iret ----
    reset_enable();
    irq = 4'h8; half(); fin();
    irq = 4'h0; ret_pc_in = 10'h100; half();
    chk("b_take_l3", 32'(take_b), 32'd1); chk("b_vec_l3", 32'(vec_b), 32'h3CC); fin();
    irq = 4'h4; half(); fin();
    irq = 4'h0; ret_pc_in = 10'h200; half();
    chk("b_take_l2", 32'(take_b), 32'd1); chk("b_vec_l2", 32'(vec_b), 32'h3C8); fin();
    irq = 4'h1; half(); chk("b_depth_full", 32'(depth_b), 32'd2); fin();
    irq = 4'h0; half();
    chk("b_full_take", 32'(take_b), 32'd0); chk("b_full_pend", 32'(pend_b), 32'h1); fin();
    half();
    chk("b_full_take2", 32'(take_b), 32'd0); chk("b_full_pend2", 32'(pend_b), 32'h1);
    chk("b_full_depth2", 32'(depth_b), 32'd2); fin();
    iret = 1'b1; half();
    chk("b_iret_take", 32'(take_b), 32'd0); chk("b_iret_ret", 32'(ret_b), 32'h200); fin();
    iret = 1'b0; half();
    chk("b_after_take", 32'(take_b), 32'd1); chk("b_after_vec", 32'(vec_b), 32'h3C0);
    chk("b_after_depth", 32'(depth_b), 32'd1); fin();

    // ---- randomized traffic against the model ----
    reset_enable();
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(0, 299) != 0);
      irq       = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      iret      = ($urandom_range(0, 3) == 0);
      mask_we   = ($urandom_range(0, 31) == 0);
      mask_in   = 4'($urandom);
      gie_we    = ($urandom_range(0, 63) == 0);
      gie_in    = ($urandom_range(0, 4) != 0);
      ret_pc_in = 10'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        timer_en    = ~timer_en;
        timer_limit = 7'($urandom_range(0, 12));
      end
      half();
      fin();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
